// File: rtl/pronoc_pkg.sv
// pronoc_pkg
// Shared NoC helpers used by the switch allocator and the crossbar:
//   - log2           : ceiling log2, minimum 1 bit
//   - p_1_of         : ports per request/grant slice (own port removed unless self loop)
//   - local_idx      : bit inside input i's slice that addresses absolute output o
//   - abs_idx        : absolute output addressed by bit k of input i's slice
// No ports (package).
package pronoc_pkg;

  localparam int DEFAULT_P = 5;

  function automatic int log2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

  function automatic int p_1_of(input int p, input int self_loop_en);
    return (self_loop_en != 0) ? p : p - 1;
  endfunction

  function automatic int local_idx(input int in_i, input int out_o, input int self_loop_en);
    if (self_loop_en != 0) begin
      return out_o;
    end else if (out_o < in_i) begin
      return out_o;
    end else begin
      return out_o - 1;
    end
  endfunction

  function automatic int abs_idx(input int in_i, input int loc_k, input int self_loop_en);
    if (self_loop_en != 0) begin
      return loc_k;
    end else if (loc_k < in_i) begin
      return loc_k;
    end else begin
      return loc_k + 1;
    end
  endfunction

endpackage

// File: rtl/wormhole_switch_allocator_if.sv
// wormhole_switch_allocator_if
// Request/grant bundle between the router input stage and the switch allocator.
//   req_dest_port_all     : per-input one-hot requested output (packed, own port removed)
//   flit_tail_all         : per-input tail marker of the presented flit
//   dest_ready_all        : per-output ready for one flit
//   granted_dest_port_all : per-input one-hot granted output, same encoding as the request
//   in_grant_all          : per-input flit transfer this cycle
//   out_busy_all          : per-output packet lock
//   alloc_err             : sticky allocation error
// master: request side; slave: allocator side.
interface wormhole_switch_allocator_if #(
  parameter int P            = 5,
  parameter int SELF_LOOP_EN = 0
);
  import pronoc_pkg::*;

  localparam int P_1  = p_1_of(P, SELF_LOOP_EN);
  localparam int PP_1 = P * P_1;

  logic [PP_1-1:0] req_dest_port_all;
  logic [P-1:0]    flit_tail_all;
  logic [P-1:0]    dest_ready_all;
  logic [PP_1-1:0] granted_dest_port_all;
  logic [P-1:0]    in_grant_all;
  logic [P-1:0]    out_busy_all;
  logic            alloc_err;

  modport master (
    output req_dest_port_all, flit_tail_all, dest_ready_all,
    input  granted_dest_port_all, in_grant_all, out_busy_all, alloc_err
  );

  modport slave (
    input  req_dest_port_all, flit_tail_all, dest_ready_all,
    output granted_dest_port_all, in_grant_all, out_busy_all, alloc_err
  );

endinterface

// File: rtl/out_port_rr_lock_arbiter.sv
// out_port_rr_lock_arbiter
// One output port: round-robin arbitration among requesting inputs, with the
// winner's packet locked onto the output until its tail flit is granted.
//   clk, reset : clock and synchronous active-high reset
//   req        : bit i = input i requests this output (already filtered)
//   tail       : bit i = flit at input i is a tail
//   ready      : output can accept a flit this cycle
//   grant      : one-hot granted input (combinational, zero while reset)
//   locked     : output holds a packet in progress
//   owner      : input holding the lock
module out_port_rr_lock_arbiter
  import pronoc_pkg::*;
#(
  parameter int P  = 5,
  parameter int PW = log2(P)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [P-1:0]  req,
  input  logic [P-1:0]  tail,
  input  logic          ready,
  output logic [P-1:0]  grant,
  output logic          locked,
  output logic [PW-1:0] owner
);

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_LOCKED = 1'b1;
  localparam logic [PW-1:0] RR_INIT   = PW'(P - 1);

  logic [0:0]    state_r;
  logic [PW-1:0] owner_r;
  logic [PW-1:0] rr_ptr_r;
  logic          rr_found_s;
  logic [PW-1:0] rr_win_s;
  logic          grant_vld_s;
  logic [PW-1:0] grant_idx_s;

  // Round-robin search: first requester after the last granted input.
  always_comb begin
    rr_found_s = 1'b0;
    rr_win_s   = '0;
    for (int d = 1; d <= P; d++) begin
      if (!rr_found_s && req[(int'(rr_ptr_r) + d) % P]) begin
        rr_found_s = 1'b1;
        rr_win_s   = PW'((int'(rr_ptr_r) + d) % P);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant selection: free arbitration when idle, owner only when locked.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    if (reset) begin
      grant_vld_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          grant_vld_s = rr_found_s & ready;
          grant_idx_s = rr_win_s;
        end
        ST_LOCKED: begin
          grant_vld_s = req[owner_r] & ready;
          grant_idx_s = owner_r;
        end
        default: begin
          grant_vld_s = 1'b0;
        end
      endcase
    end
  end

  // One-hot grant vector.
  always_comb begin
    grant = '0;
    if (grant_vld_s) begin
      grant[grant_idx_s] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Lock / owner / round-robin pointer; only a grant moves the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      owner_r  <= '0;
      rr_ptr_r <= RR_INIT;
    end else if (grant_vld_s) begin
      case (state_r)
        ST_IDLE: begin
          rr_ptr_r <= grant_idx_s;
          if (!tail[grant_idx_s]) begin
            state_r <= ST_LOCKED;
            owner_r <= grant_idx_s;
          end
        end
        ST_LOCKED: begin
          if (tail[grant_idx_s]) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign locked = (state_r == ST_LOCKED);
  assign owner  = owner_r;

endmodule

// File: rtl/wormhole_switch_allocator.sv
// wormhole_switch_allocator
// Per-output-port switch allocator for a wormhole router. Produces the
// crossbar's packed, self-port-removed one-hot grant vectors.
//   clk, reset : clock and synchronous active-high reset
//   bus        : request/grant bundle (slave side), see the interface header
module wormhole_switch_allocator
  import pronoc_pkg::*;
#(
  parameter int NOC_ID       = 0,
  parameter int P            = 5,
  parameter int SELF_LOOP_EN = 0
) (
  input logic                          clk,
  input logic                          reset,
  wormhole_switch_allocator_if.slave   bus
);

  localparam int P_1  = p_1_of(P, SELF_LOOP_EN);
  localparam int PP_1 = P * P_1;
  localparam int PW   = log2(P);

  logic [P_1-1:0]  slice_s   [P];
  logic [P_1-1:0]  low_s     [P];
  logic [P-1:0]    multi_s;
  logic [P-1:0]    active_s;
  logic [P-1:0]    pre_req_s [P];
  logic [P-1:0]    out_req_s [P];
  logic [P-1:0]    grant_s   [P];
  logic [P-1:0]    locked_s;
  logic [PW-1:0]   owner_s   [P];
  logic [P-1:0]    blocked_s;
  logic            mismatch_s;
  logic [PP_1-1:0] granted_s;
  logic [P-1:0]    in_grant_s;
  logic            alloc_err_r;

  // Keep only the lowest set bit of each request slice; flag multi-hot slices.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      slice_s[i]  = bus.req_dest_port_all[i*P_1 +: P_1];
      low_s[i]    = slice_s[i] & (~slice_s[i] + P_1'(1));
      multi_s[i]  = |(slice_s[i] & (slice_s[i] - P_1'(1)));
      active_s[i] = |slice_s[i];
    end
  end

  // Transpose input slices into per-output request vectors (absolute input index).
  always_comb begin
    for (int o = 0; o < P; o++) begin
      for (int i = 0; i < P; i++) begin
        if ((SELF_LOOP_EN == 0) && (i == o)) begin
          pre_req_s[o][i] = 1'b0;
        end else begin
          pre_req_s[o][i] = low_s[i][local_idx(i, o, SELF_LOOP_EN)];
        end
      end
    end
  end

  // A locked owner asking for another output is refused everywhere else.
  // Built from registered lock state and raw requests, so no loop through grants.
  always_comb begin
    blocked_s  = '0;
    mismatch_s = 1'b0;
    for (int o = 0; o < P; o++) begin
      if (locked_s[o] && active_s[owner_s[o]] && !pre_req_s[o][owner_s[o]]) begin
        blocked_s[owner_s[o]] = 1'b1;
        mismatch_s            = 1'b1;
      end else begin
        mismatch_s = mismatch_s;
      end
    end
  end

  // Final per-output requests with blocked owners removed.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      out_req_s[o] = pre_req_s[o] & ~blocked_s;
    end
  end

  for (genvar o = 0; o < P; o++) begin : g_out
    out_port_rr_lock_arbiter #(
      .P  (P),
      .PW (PW)
    ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (out_req_s[o]),
      .tail   (bus.flit_tail_all),
      .ready  (bus.dest_ready_all[o]),
      .grant  (grant_s[o]),
      .locked (locked_s[o]),
      .owner  (owner_s[o])
    );
  end

  // Transpose per-output grants back into per-input packed slices.
  always_comb begin
    granted_s  = '0;
    in_grant_s = '0;
    for (int i = 0; i < P; i++) begin
      for (int k = 0; k < P_1; k++) begin
        granted_s[i*P_1 + k] = grant_s[abs_idx(i, k, SELF_LOOP_EN)][i];
      end
      in_grant_s[i] = |granted_s[i*P_1 +: P_1];
    end
  end

  // Sticky allocation error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_err_r <= 1'b0;
    end else begin
      alloc_err_r <= alloc_err_r | (|multi_s) | mismatch_s;
    end
  end

  assign bus.granted_dest_port_all = granted_s;
  assign bus.in_grant_all          = in_grant_s;
  assign bus.out_busy_all          = reset ? '0 : locked_s;
  assign bus.alloc_err             = alloc_err_r;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// tb_wormhole_switch_allocator
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the allocation rules.
module tb_wormhole_switch_allocator;

  localparam int P    = 5;
  localparam int P_1  = 4;
  localparam int PP_1 = 20;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wormhole_switch_allocator_if #(.P(P), .SELF_LOOP_EN(0)) bus ();

  wormhole_switch_allocator #(
    .NOC_ID       (0),
    .P            (P),
    .SELF_LOOP_EN (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model state: per output lock flag, owner and last granted input.
  bit m_locked [P];
  int m_owner  [P];
  int m_last   [P];
  bit m_err;
  bit m_known;

  int total;
  int passed;
  int fails;

  logic [PP_1-1:0] obs_g;
  logic [P-1:0]    obs_ig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int loc(input int i, input int o);
    return (o < i) ? o : o - 1;
  endfunction

  task automatic set_req(input int i, input int o);
    bus.req_dest_port_all[i*P_1 +: P_1] = '0;
    bus.req_dest_port_all[i*P_1 + loc(i, o)] = 1'b1;
  endtask

  task automatic drop(input int i);
    bus.req_dest_port_all[i*P_1 +: P_1] = '0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    int tgt [P];
    bit blk [P];
    int win [P];
    int nb;
    int c;
    bit err_now;
    logic [PP_1-1:0] eg;
    logic [P-1:0] eig;
    logic [P-1:0] ebusy;
    logic [P-1:0] tl;
    @(negedge clk);
    err_now = 1'b0;
    eg = '0;
    eig = '0;
    ebusy = '0;
    tl = bus.flit_tail_all;
    for (int i = 0; i < P; i++) begin
      tgt[i] = -1;
      blk[i] = 1'b0;
      nb = 0;
      for (int k = 0; k < P_1; k++) begin
        if (bus.req_dest_port_all[i*P_1 + k]) begin
          nb++;
          if (tgt[i] < 0) tgt[i] = (k < i) ? k : k + 1;
        end
      end
      if (nb > 1) err_now = 1'b1;
    end
    for (int o = 0; o < P; o++) begin
      if (m_locked[o] && tgt[m_owner[o]] >= 0 && tgt[m_owner[o]] != o) begin
        blk[m_owner[o]] = 1'b1;
        err_now = 1'b1;
      end
    end
    for (int o = 0; o < P; o++) begin
      win[o] = -1;
      if (m_locked[o]) begin
        if (tgt[m_owner[o]] == o) win[o] = m_owner[o];
      end else begin
        for (int j = 1; j <= P; j++) begin
          c = (m_last[o] + j) % P;
          if (win[o] < 0 && tgt[c] == o && !blk[c]) win[o] = c;
        end
      end
      if (!bus.dest_ready_all[o] || reset) win[o] = -1;
      if (win[o] >= 0) begin
        eg[win[o]*P_1 + loc(win[o], o)] = 1'b1;
        eig[win[o]] = 1'b1;
      end
      ebusy[o] = m_locked[o] && !reset;
    end
    obs_g  = bus.granted_dest_port_all;
    obs_ig = bus.in_grant_all;
    chk("grant", 32'(bus.granted_dest_port_all), 32'(eg));
    chk("in_grant", 32'(bus.in_grant_all), 32'(eig));
    chk("out_busy", 32'(bus.out_busy_all), 32'(ebusy));
    if (m_known) chk("alloc_err", 32'(bus.alloc_err), 32'(m_err));
    @(posedge clk);
    if (reset) begin
      for (int o = 0; o < P; o++) begin
        m_locked[o] = 1'b0;
        m_owner[o]  = 0;
        m_last[o]   = P - 1;
      end
      m_err   = 1'b0;
      m_known = 1'b1;
    end else begin
      m_err = m_err | err_now;
      for (int o = 0; o < P; o++) begin
        if (win[o] >= 0) begin
          if (m_locked[o]) begin
            if (tl[win[o]]) m_locked[o] = 1'b0;
          end else begin
            m_last[o] = win[o];
            if (!tl[win[o]]) begin
              m_locked[o] = 1'b1;
              m_owner[o]  = win[o];
            end
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    int cnt [P];
    int r;
    total = 0;
    passed = 0;
    fails = 0;
    m_known = 1'b0;
    m_err = 1'b0;
    for (int o = 0; o < P; o++) begin
      m_locked[o] = 1'b0;
      m_owner[o]  = 0;
      m_last[o]   = P - 1;
    end
    reset = 1'b1;
    bus.req_dest_port_all = '0;
    bus.flit_tail_all = '1;
    bus.dest_ready_all = '1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", 32'(bus.out_busy_all), 32'h0);
    chk("reset_err", 32'(bus.alloc_err), 32'h0);

    // Reset priority: input 1 before input 3 on output 2.
    set_req(1, 2);
    set_req(3, 2);
    tick();
    chk("s1_first", 32'(obs_g), 32'h20);
    tick();
    chk("s1_second", 32'(obs_g), 32'h4000);
    drop(1);
    drop(3);
    tick();

    // Lock hold: 4-flit packet 0->4 while input 2 competes.
    set_req(0, 4);
    set_req(2, 4);
    bus.flit_tail_all = 5'b00100;
    tick();
    tick();
    chk("s2_busy", 32'(bus.out_busy_all), 32'h10);
    tick();
    bus.flit_tail_all = 5'b00101;
    tick();
    chk("s2_tail", 32'(obs_ig), 32'h01);
    drop(0);
    tick();
    chk("s2_next", 32'(obs_ig), 32'h04);
    drop(2);
    tick();

    // Backpressure mid-packet.
    set_req(0, 4);
    set_req(2, 4);
    bus.flit_tail_all = 5'b00100;
    tick();
    bus.dest_ready_all = 5'b01111;
    for (int s = 0; s < 3; s++) tick();
    chk("s3_stall_busy", 32'(bus.out_busy_all), 32'h10);
    bus.dest_ready_all = '1;
    tick();
    bus.flit_tail_all = 5'b00101;
    tick();
    drop(0);
    tick();
    drop(2);
    tick();

    // Fairness among inputs 0, 1, 3, 4 on output 2.
    bus.flit_tail_all = '1;
    for (int i = 0; i < P; i++) cnt[i] = 0;
    set_req(0, 2);
    set_req(1, 2);
    set_req(3, 2);
    set_req(4, 2);
    for (int s = 0; s < 40; s++) begin
      tick();
      for (int i = 0; i < P; i++) if (obs_ig[i]) cnt[i]++;
    end
    chk("fair_0", 32'(cnt[0]), 32'd10);
    chk("fair_1", 32'(cnt[1]), 32'd10);
    chk("fair_3", 32'(cnt[3]), 32'd10);
    chk("fair_4", 32'(cnt[4]), 32'd10);
    bus.req_dest_port_all = '0;
    tick();

    // Multi-hot slice on input 1: lowest bit (output 2) honoured, error sticky.
    bus.req_dest_port_all[1*P_1 +: P_1] = 4'b0110;
    tick();
    chk("s5_multi_grant", 32'(obs_g), 32'h20);
    drop(1);
    tick();
    tick();
    chk("s5_sticky", 32'(bus.alloc_err), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Locked owner switches its request.
    set_req(0, 4);
    bus.flit_tail_all = 5'b00000;
    tick();
    set_req(0, 2);
    tick();
    chk("s5_switch_grant", 32'(obs_ig), 32'h0);
    tick();
    chk("s5_switch_err", 32'(bus.alloc_err), 32'h1);
    drop(0);

    // Reset mid-packet, then another input takes the output at once.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 4);
    set_req(2, 4);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("s6_reset_grant", 32'(obs_g), 32'h0);
    reset = 1'b0;
    drop(0);
    tick();
    chk("s6_new_owner", 32'(obs_ig), 32'h04);
    bus.flit_tail_all = 5'b00100;
    tick();
    drop(2);
    tick();

    // Randomized traffic.
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < P; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3) begin
          drop(i);
        end else if (r == 9) begin
          bus.req_dest_port_all[i*P_1 +: P_1] = 4'($urandom_range(1, 15));
        end else begin
          r = int'($urandom_range(0, P - 2));
          set_req(i, (r < i) ? r : r + 1);
        end
      end
      bus.flit_tail_all  = 5'($urandom);
      bus.dest_ready_all = 5'($urandom) | 5'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wormhole_switch_allocator.md
# wormhole_switch_allocator

Per-output-port switch allocator that generates the crossbar's one-hot grant vectors for a wormhole router. Each output port runs a round-robin arbiter among the input ports requesting it. The winner's packet is locked onto that output until its tail flit crosses. Grants feed the crossbar's `granted_dest_port_all` directly, in the same packed, self-port-removed format.

## Interface
Parameters:
- `NOC_ID`, 0, NoC instance identifier, passed through for package lookup
- `P`, 5, router port count
- `SELF_LOOP_EN`, 0, 1: an input may target its own output; 0: own port removed from every vector, so P_1 = P-1
- derived `P_1` = SELF_LOOP_EN ? P : P-1; `PP_1` = P*P_1; `Pw` = log2(P)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_dest_port_all`  in  PP_1  per input i, slice [i*P_1 +: P_1]: one-hot requested output, self port removed when SELF_LOOP_EN=0; all-zero means no request
- `flit_tail_all`  in  P  bit i: the flit presented at input i this cycle is a tail (single-flit packets assert both head and tail)
- `dest_ready_all`  in  P  bit o: output o can accept one flit this cycle
- `granted_dest_port_all`  out  PP_1  per input i: one-hot output granted this cycle, same encoding as the request
- `in_grant_all`  out  P  bit i: input i transfers a flit this cycle (OR of its grant slice)
- `out_busy_all`  out  P  bit o: output o is locked to a packet in progress
- `alloc_err`  out  1  sticky: a multi-hot request slice was seen, or a locked owner requested a different output

## Operation
- **Index mapping** (SELF_LOOP_EN=0):
  - Input i, local bit k targets output o = (k<i) ? k : k+1.
  - Output o sees input i at request bit (o<i) ? o : o-1.
  - With SELF_LOOP_EN=1 the mapping is the identity.
- **Per-output state:** `lock` (1 bit), `owner` (Pw), `rr_ptr` (Pw, last granted input). Two states:
  - IDLE. The arbiter considers all inputs requesting o. Priority order is rr_ptr+1, rr_ptr+2, …, wrapping modulo P. The highest-priority requester wins, and a grant is issued only if `dest_ready_all[o]`=1.
    - On a grant, rr_ptr ← winner.
    - If the granted flit is not a tail: lock←1, owner←winner, go to LOCKED.
    - If the granted flit is a tail (single-flit packet): stay in IDLE.
  - LOCKED. Only `owner` can be granted, and only when it requests o and dest_ready[o]=1. All other requesters are blocked. A granted tail flit clears lock and returns the output to IDLE. rr_ptr does not change while LOCKED.
- **Per-input uniqueness:** a request slice is one-hot, so an input wins at most one output per cycle. For a multi-hot slice, only the lowest set bit is honoured and `alloc_err` is set.
- **Owner mismatch:** if a locked owner requests another output, that request is not granted, the lock is held, and `alloc_err` is set.
- **Requests without ready:** a request with dest_ready=0 leaves all state unchanged.
- **Reset:**
  - lock=0, owner=0, rr_ptr=P-1 on all outputs (input 0 has first priority).
  - alloc_err=0.
  - All grant, `in_grant_all` and `out_busy_all` outputs are forced to 0 while reset=1.
  - A packet in progress is abandoned; the lock is not restored.

## Timing
- Grant is combinational from the current requests, dest_ready and registered state: zero-cycle latency, same cycle as the flit reaches the crossbar.
- State updates at the clock edge following a grant.
- After a non-tail head is granted, `out_busy_all[o]` rises the next cycle. It falls the cycle after the tail is granted.
- Back-to-back packets: a new head can win output o in the cycle right after the previous tail (no bubble).
- Simultaneous events:
  - A tail grant and a competing head request in the same cycle: the head waits one cycle for arbitration.
  - Two outputs free their locks in the same cycle: each arbitrates independently.
- No combinational path from `granted_dest_port_all` back into the block's inputs is permitted.

## Structure
- Shared package `pronoc_pkg`: the `log2` function, the P_1/PP_1 derivation, and the self-port index-remap helpers (local↔absolute), reused by the crossbar.
- Sub-module `out_port_rr_lock_arbiter`, instantiated P times. It holds the lock/owner/rr_ptr state and the P-input round-robin arbiter.
- The top level only does remapping, per-input lowest-bit masking, output-to-input transpose, the in_grant OR, and the error flag.
- Target size 200–300 lines.

## Test plan
All scenarios use P=5, SELF_LOOP_EN=0.

1. **Reset priority.** Release reset; inputs 1 and 3 both request output 2 with single-flit packets, ready=1 → input 1 granted (bit 1 of slice 1 set), then input 3 the next cycle. `out_busy_all` stays 0 throughout.
2. **Lock hold.** Input 0 sends a 4-flit packet to output 4 while input 2 also requests output 4 → input 0 gets 4 consecutive grants. `out_busy_all[4]`=1 for cycles 2–4. Input 2 is granted in cycle 5.
3. **Backpressure.** Locked packet 0→4, `dest_ready_all[4]`=0 for 3 cycles mid-packet → no grants during the stall, lock held, input 2 still blocked, and the packet resumes when ready returns.
4. **Fairness.** Inputs 0, 1, 3, 4 continuously request output 2 with single-flit packets → grant order 0, 1, 3, 4, 0, … with equal counts over 40 cycles.
5. **Errors.** Input 1 drives slice 4'b0110 → output 2 (local bit 1) is granted and `alloc_err`=1 stays sticky until reset. Separately, a locked owner switching its request → no grant and `alloc_err`=1.
6. **Reset mid-packet.** reset=1 mid-packet → grants are 0 that cycle. After release, `out_busy_all`=0 and a different input can win the previously locked output immediately.
